keynsham_irq_vic: RTL and testbench
===================================

// Module: keynsham_irq_vic
// PURPOSE
//  Parametrised vectored IRQ controller; successor to the basic 32-source controller.
//  Adds per-source level/edge mode, latched edge pending with write-1-to-clear,
//  optional input synchroniser, and a fixed-priority vector (lowest index wins).
//  Sits on the Keynsham data bus; drives the CPU irq_req line and a vector output.
// PARAMETERS
//  bus_address   32'h0   base address, passed to cs_gen
//  bus_size      32'h0   decode window size, passed to cs_gen
//  nr_irqs       8       number of sources, 1..32
//  sync_inputs   1       1: 2-flop synchroniser on irq_in; 0: irq_in used directly
//  edge_reset    32'h0   reset value of the EDGE register (bit=1: rising-edge source)
// PORTS
//  clk          in   1        clock; single clock domain
//  rst          in   1        reset; synchronous, active-high
//  bus_access   in   1        bus cycle strobe
//  bus_cs       out  1        chip select from cs_gen(bus_addr)
//  bus_addr     in   30       word address; bits [2:0] select the register
//  bus_wr_val   in   32       write data
//  bus_wr_en    in   1        1 = write, 0 = read
//  bus_bytesel  in   4        ignored; all accesses are full-word
//  bus_error    out  1        error flag, valid with bus_ack
//  bus_ack      out  1        one-cycle completion pulse
//  bus_data     out  32       read data; 0 when bus_ack = 0
//  irq_in       in   nr_irqs  raw interrupt sources, active-high
//  irq_req      out  1        to CPU: any enabled source pending
//  irq_vec      out  6        {valid, index[4:0]} of highest-priority active source
// BEHAVIOUR
//  Word offsets (bus_addr[2:0]):
//   0 STATUS   RO
//   1 ENABLE   RW; write ORs into enable
//   2 DISABLE  WO; write clears enable bits; reads 0
//   3 TEST     RW
//   4 EDGE     RW
//   5 CLEAR    W1C edge-pending; reads 0
//   6 VECTOR   RO; {26'b0, irq_vec}
//   7 RAW      RO; synchronised irq_in
//  Register bits >= nr_irqs read 0 and ignore writes.
//  Source path:
//   - in_s = irq_in after sync_inputs flops (2 cycles latency, or 0); in_d = in_s delayed 1 cycle.
//   - Edge source: pend[i] sets on in_s & ~in_d. CLEAR write of 1 clears it.
//     Set and clear in the same cycle: set wins (pend stays 1).
//   - Level source: pend[i] = in_s[i] combinationally; CLEAR has no effect.
//   - Writing EDGE changes a source's mode; bit leaving edge mode clears its pend latch.
//   - active = (pend | TEST) & ENABLE. STATUS reads active.
//  Priority: irq_vec index = lowest set bit of active; valid = |active; index = 0 when none.
//  Outputs:
//   - irq_req and irq_vec are registered from active: 1 cycle after active changes.
//   - Total level-input latency with sync_inputs = 1 is 3 cycles to irq_req.
//  Bus:
//   - bus_ack <= bus_access & bus_cs, i.e. exactly one cycle after the strobe, no stalls.
//   - Read data is captured at the strobe cycle and presented only while bus_ack = 1.
//   - Writes take effect at the clock edge ending the strobe cycle.
//   - Writes to STATUS, VECTOR or RAW are ignored and assert bus_error with bus_ack; all other accesses return bus_error = 0.
//   - Back-to-back strobes each get their own ack.
//  Reset (synchronous):
//   - ENABLE = 0, TEST = 0, EDGE = edge_reset, pend latches = 0, sync flops = 0.
//   - Outputs: irq_req = 0, irq_vec = 0, bus_ack = 0, bus_error = 0.
//   - rst during an access suppresses its ack and its write.
// TESTING
//  1 Level: nr_irqs=8, ENABLE=0x10, hold irq_in[4]=1 -> irq_req=1 after 3 clks, VECTOR=0x24; drop irq_in -> irq_req=0 after 3 clks.
//  2 Edge: EDGE=0x01, ENABLE=0x01, 1-clk pulse on irq_in[0] -> STATUS=0x1 held; CLEAR=0x1 -> STATUS=0, irq_req=0 next clk.
//  3 Clear race: CLEAR write in the same cycle as a new rising edge on an edge source -> pend stays 1, irq_req stays 1.
//  4 Priority: ENABLE=0xFF, TEST=0x84 -> VECTOR=0x22; DISABLE=0x04 -> VECTOR=0x27; DISABLE=0x80 -> VECTOR=0, irq_req=0.
//  5 Bus: write STATUS -> bus_ack=1, bus_error=1, no state change; read offset 2 -> 0; bus_data=0 outside ack; ENABLE bit 9 with nr_irqs=8 reads 0.
//  6 Reset mid-run: pending edge + enabled, assert rst 1 clk -> all registers cleared, irq_req=0, EDGE=edge_reset.

Source files
------------

// File: rtl/keynsham_irq_vic.sv
// Vectored interrupt controller: per-source level/edge mode, W1C edge
// latches, optional input synchroniser and lowest-index-wins vector.
module keynsham_irq_vic #(
  parameter logic [31:0] bus_address = 32'h0,
  parameter logic [31:0] bus_size    = 32'h0,
  parameter int          nr_irqs     = 8,
  parameter bit          sync_inputs = 1'b1,
  parameter logic [31:0] edge_reset  = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bus_access,
  output logic               bus_cs,
  input  logic [29:0]        bus_addr,
  input  logic [31:0]        bus_wr_val,
  input  logic               bus_wr_en,
  input  logic [3:0]         bus_bytesel,
  output logic               bus_error,
  output logic               bus_ack,
  output logic [31:0]        bus_data,
  input  logic [nr_irqs-1:0] irq_in,
  output logic               irq_req,
  output logic [5:0]         irq_vec
);

  localparam int N = nr_irqs;

  logic [31:0]  byte_addr;
  logic [2:0]   off;
  logic         acc;
  logic         wr;
  logic [N-1:0] wv;
  logic [N-1:0] in_s;
  logic [N-1:0] in_d;
  logic [N-1:0] en;
  logic [N-1:0] tst;
  logic [N-1:0] edg;
  logic [N-1:0] pend;
  logic [N-1:0] edg_n;
  logic [N-1:0] clr;
  logic [N-1:0] pend_n;
  logic [N-1:0] eff;
  logic [N-1:0] active;
  logic [4:0]   idx;
  logic [31:0]  rd;
  logic [31:0]  rdata;
  logic         unused_ok;

  assign byte_addr = {bus_addr, 2'b00};
  assign bus_cs = (byte_addr >= bus_address) &&
                  ((byte_addr - bus_address) < bus_size);

  assign off = bus_addr[2:0];
  assign acc = bus_access & bus_cs;
  assign wr  = acc & bus_wr_en;
  assign wv  = bus_wr_val[N-1:0];

  assign unused_ok = ^{bus_bytesel, bus_wr_val};

  generate
    if (sync_inputs) begin : g_sync
      logic [N-1:0] s1;
      logic [N-1:0] s2;
      // two-flop synchroniser on the raw sources
      always_ff @(posedge clk) begin
        if (rst) begin
          s1 <= '0;
          s2 <= '0;
        end else begin
          s1 <= irq_in;
          s2 <= s1;
        end
      end
      assign in_s = s2;
    end else begin : g_nosync
      assign in_s = irq_in;
    end
  endgenerate

  // new edge mode, clear mask and next edge latch state
  always_comb begin
    edg_n = edg;
    clr   = '0;
    if (wr && off == 3'd4) edg_n = wv;
    if (wr && off == 3'd5) clr = wv;
    pend_n = edg_n & ((pend & ~clr) | (in_s & ~in_d));
  end

  assign eff    = (edg & pend) | (~edg & in_s);
  assign active = (eff | tst) & en;

  // lowest set bit of active wins
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (active[i]) idx = 5'(i);
    end
  end

  // control registers and edge latches
  always_ff @(posedge clk) begin
    if (rst) begin
      en   <= '0;
      tst  <= '0;
      edg  <= edge_reset[N-1:0];
      pend <= '0;
      in_d <= '0;
    end else begin
      if (wr && off == 3'd1) en <= en | wv;
      if (wr && off == 3'd2) en <= en & ~wv;
      if (wr && off == 3'd3) tst <= wv;
      edg  <= edg_n;
      pend <= pend_n;
      in_d <= in_s;
    end
  end

  // register read mux
  always_comb begin
    rd = '0;
    case (off)
      3'd0:    rd[N-1:0] = active;
      3'd1:    rd[N-1:0] = en;
      3'd3:    rd[N-1:0] = tst;
      3'd4:    rd[N-1:0] = edg;
      3'd6:    rd[5:0]   = irq_vec;
      3'd7:    rd[N-1:0] = in_s;
      default: rd = '0;
    endcase
  end

  // CPU-facing interrupt outputs, one cycle behind active
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_req <= 1'b0;
      irq_vec <= '0;
    end else begin
      irq_req <= |active;
      irq_vec <= (|active) ? {1'b1, idx} : 6'd0;
    end
  end

  // bus response: single-cycle ack, read data held only for the ack
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_ack   <= 1'b0;
      bus_error <= 1'b0;
      rdata     <= '0;
    end else begin
      bus_ack   <= acc;
      bus_error <= wr & (off == 3'd0 || off == 3'd6 || off == 3'd7);
      rdata     <= (acc && !bus_wr_en) ? rd : 32'd0;
    end
  end

  assign bus_data = bus_ack ? rdata : 32'd0;

endmodule

// File: tb/tb_keynsham_irq_vic.sv
// Bench for keynsham_irq_vic: directed table, hand sequences and a
// randomized run against a cycle-level reference model.
module tb_keynsham_irq_vic;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] SIZE  = 32'h20;
  localparam logic [31:0] ERST  = 32'h2;
  localparam logic [29:0] BASEW = 30'h400;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_access;
  logic        bus_cs;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_val;
  logic        bus_wr_en;
  logic [3:0]  bus_bytesel;
  logic        bus_error;
  logic        bus_ack;
  logic [31:0] bus_data;
  logic [7:0]  irq_in;
  logic        irq_req;
  logic [5:0]  irq_vec;

  keynsham_irq_vic #(
    .bus_address(BASE),
    .bus_size(SIZE),
    .nr_irqs(8),
    .sync_inputs(1'b1),
    .edge_reset(ERST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_access(bus_access),
    .bus_cs(bus_cs),
    .bus_addr(bus_addr),
    .bus_wr_val(bus_wr_val),
    .bus_wr_en(bus_wr_en),
    .bus_bytesel(bus_bytesel),
    .bus_error(bus_error),
    .bus_ack(bus_ack),
    .bus_data(bus_data),
    .irq_in(irq_in),
    .irq_req(irq_req),
    .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference model state
  bit [7:0]  m_s1, m_s2, m_ind;
  bit [7:0]  m_en, m_tst, m_edg, m_pend;
  bit        m_req, m_ack, m_err;
  bit [5:0]  m_vec;
  bit [31:0] m_data;

  function automatic bit in_win(logic [29:0] a);
    logic [31:0] b;
    b = {a, 2'b00};
    return (b >= BASE) && ((b - BASE) < SIZE);
  endfunction

  function automatic bit [5:0] vec_of(bit [7:0] a);
    bit [7:0] lsb;
    if (a == 8'd0) return 6'd0;
    lsb = a & (~a + 8'd1);
    return {1'b1, 5'($countones(lsb - 8'd1))};
  endfunction

  task automatic model_step();
    bit [7:0] ins, act, rd8, wv, clr, rise;
    bit sel, wr;
    int off;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_ind = 0;
      m_en = 0; m_tst = 0; m_edg = ERST[7:0]; m_pend = 0;
      m_req = 0; m_vec = 0; m_ack = 0; m_err = 0; m_data = 0;
      return;
    end
    ins = m_s2;
    act = ((m_edg & m_pend) | (~m_edg & ins) | m_tst) & m_en;
    sel = bus_access && in_win(bus_addr);
    wr  = sel && bus_wr_en;
    off = int'(bus_addr[2:0]);
    wv  = bus_wr_val[7:0];
    case (off)
      0: rd8 = act;
      1: rd8 = m_en;
      3: rd8 = m_tst;
      4: rd8 = m_edg;
      6: rd8 = {2'b00, m_vec};
      7: rd8 = ins;
      default: rd8 = 0;
    endcase
    m_ack  = sel;
    m_err  = wr && (off == 0 || off == 6 || off == 7);
    m_data = (sel && !bus_wr_en) ? {24'd0, rd8} : 32'd0;
    m_req  = |act;
    m_vec  = vec_of(act);
    rise   = ins & ~m_ind;
    clr    = (wr && off == 5) ? wv : 8'd0;
    m_pend = (m_pend & ~clr) | rise;
    if (wr) begin
      case (off)
        1: m_en = m_en | wv;
        2: m_en = m_en & ~wv;
        3: m_tst = wv;
        4: m_edg = wv;
        default: ;
      endcase
    end
    m_pend = m_pend & m_edg;
    m_ind  = ins;
    m_s2   = m_s1;
    m_s1   = irq_in;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model",
          {22'd0, bus_cs, irq_req, irq_vec, bus_ack, bus_error, bus_data},
          {22'd0, in_win(bus_addr), m_req, m_vec, m_ack, m_err, m_data});
  endtask

  task automatic bus(input bit wr, input int off, input logic [31:0] d);
    bus_access = 1'b1;
    bus_wr_en  = wr;
    bus_addr   = BASEW + 30'(off);
    bus_wr_val = d;
    tick();
    bus_access = 1'b0;
    bus_wr_en  = 1'b0;
  endtask

  task automatic rd(input int off, output logic [31:0] v);
    bus(1'b0, off, 32'd0);
    v = bus_data;
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  off;
    logic [31:0] d;
    bit          err;
    logic [31:0] q;
  } row_t;

  row_t tbl[18];
  logic [31:0] v;

  initial begin
    tbl = '{
      '{1'b1, 3'd1, 32'hFF,  1'b0, 32'h00},
      '{1'b1, 3'd3, 32'h84,  1'b0, 32'h00},
      '{1'b0, 3'd6, 32'h0,   1'b0, 32'h22},
      '{1'b1, 3'd2, 32'h04,  1'b0, 32'h00},
      '{1'b0, 3'd6, 32'h0,   1'b0, 32'h27},
      '{1'b1, 3'd2, 32'h80,  1'b0, 32'h00},
      '{1'b0, 3'd6, 32'h0,   1'b0, 32'h00},
      '{1'b0, 3'd0, 32'h0,   1'b0, 32'h00},
      '{1'b1, 3'd0, 32'hFF,  1'b1, 32'h00},
      '{1'b0, 3'd1, 32'h0,   1'b0, 32'h7B},
      '{1'b0, 3'd2, 32'h0,   1'b0, 32'h00},
      '{1'b1, 3'd1, 32'h300, 1'b0, 32'h00},
      '{1'b0, 3'd1, 32'h0,   1'b0, 32'h7B},
      '{1'b1, 3'd6, 32'hFF,  1'b1, 32'h00},
      '{1'b1, 3'd7, 32'hFF,  1'b1, 32'h00},
      '{1'b0, 3'd5, 32'h0,   1'b0, 32'h00},
      '{1'b0, 3'd3, 32'h0,   1'b0, 32'h84},
      '{1'b0, 3'd4, 32'h0,   1'b0, 32'h01}
    };

    rst = 1'b1;
    bus_access = 1'b0;
    bus_addr = BASEW;
    bus_wr_val = '0;
    bus_wr_en = 1'b0;
    bus_bytesel = 4'hF;
    irq_in = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_req", irq_req, 0);
    check("rst_vec", irq_vec, 0);
    check("rst_ack", bus_ack, 0);
    rd(4, v);
    check("rst_edge", v, ERST);

    // level source
    bus(1'b1, 1, 32'h10);
    irq_in = 8'h10;
    tick();
    tick();
    check("lvl_req_2clk", irq_req, 0);
    tick();
    check("lvl_req_3clk", irq_req, 1);
    rd(6, v);
    check("lvl_vector", v, 32'h24);
    irq_in = 8'h00;
    tick();
    tick();
    check("lvl_drop_2clk", irq_req, 1);
    tick();
    check("lvl_drop_3clk", irq_req, 0);

    // edge source with W1C
    bus(1'b1, 2, 32'h10);
    bus(1'b1, 4, 32'h01);
    bus(1'b1, 1, 32'h01);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    repeat (4) tick();
    rd(0, v);
    check("edge_status", v, 32'h1);
    repeat (3) tick();
    rd(0, v);
    check("edge_held", v, 32'h1);
    check("edge_req", irq_req, 1);
    bus(1'b1, 5, 32'h1);
    check("clr_req_same", irq_req, 1);
    tick();
    check("clr_req_next", irq_req, 0);
    rd(0, v);
    check("clr_status", v, 32'h0);

    // clear racing a new rising edge
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    repeat (4) tick();
    check("race_pre", irq_req, 1);
    irq_in = 8'h01;
    tick();
    tick();
    irq_in = 8'h00;
    bus(1'b1, 5, 32'h1);
    check("race_req", irq_req, 1);
    tick();
    check("race_req2", irq_req, 1);
    rd(0, v);
    check("race_status", v, 32'h1);
    bus(1'b1, 5, 32'h1);
    repeat (3) tick();
    check("race_cleaned", irq_req, 0);

    // priority and bus table
    foreach (tbl[i]) begin
      bus(tbl[i].wr, int'(tbl[i].off), tbl[i].d);
      check($sformatf("tbl%0d_ack", i), bus_ack, 1);
      check($sformatf("tbl%0d_err", i), bus_error, tbl[i].err);
      check($sformatf("tbl%0d_data", i), bus_data, tbl[i].q);
      tick();
      check($sformatf("tbl%0d_idle", i), {bus_ack, bus_data}, 33'd0);
    end
    check("prio_req_off", irq_req, 0);

    // reset in the middle of activity
    bus(1'b1, 3, 32'h0);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    repeat (4) tick();
    check("rst_mid_pre", irq_req, 1);
    rst = 1'b1;
    bus(1'b1, 1, 32'hFF);
    rst = 1'b0;
    check("rst_mid_ack", bus_ack, 0);
    check("rst_mid_req", irq_req, 0);
    rd(1, v);
    check("rst_mid_en", v, 0);
    rd(3, v);
    check("rst_mid_test", v, 0);
    rd(4, v);
    check("rst_mid_edge", v, ERST);
    rd(0, v);
    check("rst_mid_status", v, 0);

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      int off;
      off = int'($urandom_range(7));
      if ($urandom_range(3) == 0) irq_in = 8'($urandom);
      rst = ($urandom_range(149) == 0);
      bus_access = 1'($urandom_range(1));
      bus_wr_en = 1'($urandom_range(1));
      bus_addr = ($urandom_range(7) == 0) ? 30'h500 + 30'(off)
                                          : BASEW + 30'(off);
      bus_wr_val = $urandom;
      bus_bytesel = 4'($urandom);
      tick();
    end
    rst = 1'b0;
    bus_access = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
